// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the single-clock FIFO controller
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    NORMAL = 2'd1,
    FULL   = 2'd2
  } fifo_state_t;

  function automatic bit depth_ok(input int depth);
    return depth >= 2;
  endfunction

  function automatic int af_level_default(input int depth);
    return (2 ** depth) - 2;
  endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// rtl/fifo_ptr_counter.sv - wrapping address counter with increment enable
module fifo_ptr_counter #(
  parameter int width = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Natural overflow gives the 2**width wrap with no gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sync_controller.sv
// rtl/fifo_sync_controller.sv - same-clock FIFO address/flag controller
// Optional occupancy level and almost_full outputs under FIFO_LEVEL_EN.
module fifo_sync_controller
  import fifo_pkg::*;
#(
  parameter int depth             = 3,
  parameter int almost_full_level = af_level_default(depth)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             din_send,
  output logic             din_rdy,
  input  logic             dout_read,
  output logic             dout_rdy,
  output logic [depth-1:0] wr_address,
  output logic [depth-1:0] rd_address,
  output logic             wr_en,
  output logic             rd_en
`ifdef FIFO_LEVEL_EN
  ,
  output logic [depth:0]   level,
  output logic             almost_full
`endif
);

  if (!depth_ok(depth) || almost_full_level > 2 ** depth) begin : g_param_check
    $error("fifo_sync_controller: depth must be >= 2 and almost_full_level <= 2**depth");
  end

  fifo_state_t state, state_next;
  logic [depth-1:0] wr_next;
  logic [depth-1:0] rd_next;

  assign din_rdy  = (state != FULL);
  assign dout_rdy = (state != EMPTY);
  assign wr_en    = din_send & din_rdy;
  assign rd_en    = dout_read & dout_rdy;
  assign wr_next  = wr_address + 1'b1;
  assign rd_next  = rd_address + 1'b1;

  fifo_ptr_counter #(.width(depth)) u_wr_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (wr_en),
    .count   (wr_address)
  );

  fifo_ptr_counter #(.width(depth)) u_rd_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (rd_en),
    .count   (rd_address)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flags gate the requests, so R never fires in EMPTY and W never in FULL.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (wr_en) state_next = NORMAL;
      end
      NORMAL: begin
        if (wr_en && !rd_en && (wr_next == rd_address)) begin
          state_next = FULL;
        end else if (rd_en && !wr_en && (rd_next == wr_address)) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (rd_en) state_next = NORMAL;
      end
      default: state_next = EMPTY;
    endcase
  end

`ifdef FIFO_LEVEL_EN
  localparam logic [depth:0] af_level = (depth + 1)'(almost_full_level);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (wr_en && !rd_en) begin
      level <= level + 1'b1;
    end else if (rd_en && !wr_en) begin
      level <= level - 1'b1;
    end
  end

  assign almost_full = (level >= af_level);
`endif

endmodule

// File: tb/tb_fifo_sync_controller.sv
// tb/tb_fifo_sync_controller.sv - scoreboard bench for fifo_sync_controller (depth 3)
module tb_fifo_sync_controller;

  logic       clock;
  logic       reset_n;
  logic       din_send;
  logic       din_rdy;
  logic       dout_read;
  logic       dout_rdy;
  logic [2:0] wr_address;
  logic [2:0] rd_address;
  logic       wr_en;
  logic       rd_en;
`ifdef FIFO_LEVEL_EN
  logic [3:0] level;
  logic       almost_full;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         ew;
    bit         er;
    logic [2:0] wa;
    logic [2:0] ra;
  } exp_t;

  exp_t exp_q[$];
  int   model_wa = 0;
  int   model_ra = 0;

  fifo_sync_controller #(.depth(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din_send   (din_send),
    .din_rdy    (din_rdy),
    .dout_read  (dout_read),
    .dout_rdy   (dout_rdy),
    .wr_address (wr_address),
    .rd_address (rd_address),
    .wr_en      (wr_en),
    .rd_en      (rd_en)
`ifdef FIFO_LEVEL_EN
    ,
    .level      (level),
    .almost_full(almost_full)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared at the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wr_en", 32'(wr_en), 32'(e.ew));
      chk("rd_en", 32'(rd_en), 32'(e.er));
      if (e.ew && wr_en) chk("wr_address", 32'(wr_address), 32'(e.wa));
      if (e.er && rd_en) chk("rd_address", 32'(rd_address), 32'(e.ra));
    end
  end

  // Drive one cycle of requests with hand-stated acceptance, then step past the edge.
  task automatic step(input bit w, input bit r, input bit ew, input bit er);
    exp_t e;
    din_send  = w;
    dout_read = r;
    e.ew = ew;
    e.er = er;
    e.wa = 3'(model_wa);
    e.ra = 3'(model_ra);
    exp_q.push_back(e);
    if (ew) model_wa = (model_wa + 1) % 8;
    if (er) model_ra = (model_ra + 1) % 8;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string tag, input bit drdy, input bit qrdy, input int lvl);
    chk({tag, ".din_rdy"}, 32'(din_rdy), 32'(drdy));
    chk({tag, ".dout_rdy"}, 32'(dout_rdy), 32'(qrdy));
`ifdef FIFO_LEVEL_EN
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(lvl >= 6));
`else
    if (lvl < 0) $display("negative level %0d", lvl);
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    din_send  = 1'b0;
    dout_read = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_flags("reset", 1'b1, 1'b0, 0);
    chk("reset.wr_address", 32'(wr_address), 32'd0);
    chk("reset.rd_address", 32'(rd_address), 32'd0);
    chk("reset.wr_en", 32'(wr_en), 32'd0);
    chk("reset.rd_en", 32'(rd_en), 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Fill from EMPTY to FULL, then a rejected ninth write.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk_flags($sformatf("fill%0d", i), i != 7, 1'b1, i + 1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_flags("fill_over", 1'b0, 1'b1, 8);

    // Drain to EMPTY, then a rejected ninth read.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk_flags($sformatf("drain%0d", i), 1'b1, i != 7, 7 - i);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_flags("drain_under", 1'b1, 1'b0, 0);

    // Reset in the middle of traffic takes effect without a clock edge.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    din_send = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk_flags("midreset", 1'b1, 1'b0, 0);
    chk("midreset.wr_address", 32'(wr_address), 32'd0);
    chk("midreset.rd_address", 32'(rd_address), 32'd0);
    model_wa = 0;
    model_ra = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Wrap: 5 writes, 5 reads, 6 writes (addresses 5,6,7,0,1,2).
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk_flags("wrap_empty", 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_flags("wrap", 1'b1, 1'b1, 6);
    chk("wrap.wr_address", 32'(wr_address), 32'd3);

    // FULL with both requests: only the read is accepted.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_flags("full", 1'b0, 1'b1, 8);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk_flags("full_both", 1'b1, 1'b1, 7);

    // EMPTY with both requests: only the write is accepted.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk_flags("empty", 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_flags("empty_both", 1'b1, 1'b1, 1);

    // Steady streaming at level 3.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_flags("stream_start", 1'b1, 1'b1, 3);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_flags("stream_end", 1'b1, 1'b1, 3);
    chk("stream.wr_address", 32'(wr_address), 32'(model_wa));
    chk("stream.rd_address", 32'(rd_address), 32'(model_ra));

    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
